mem_arbiter: RTL



---
 rtl/lc3b_types.sv | 23 ++
 rtl/sat_counter.sv | 20 ++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: the core's word and cache-line types, plus the
// state and grant encodings used by the memory arbiter.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;

  // Arbiter FSM states. DONE is a one-cycle gap after every response so the
  // served cache has time to drop its request before the next grant.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // The cache that received the most recent grant.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } lc3b_grant;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, but never wrap past all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and the
// D-cache. One line transaction is in flight at a time; the winning request
// is latched at grant so cache-side changes cannot disturb the memory
// command. Simultaneous requests alternate through a round-robin flag.
//
// Handshake: a cache holds its request (i_read, d_read/d_write) high until it
// sees its one-cycle resp strobe; memory signals completion with a one-cycle
// pmem_resp while a command is asserted. The resp strobe is combinational from
// pmem_resp and the serving state, and the cache must drop its request in the
// DONE cycle that follows.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_read,
  input  lc3b_word          i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  lc3b_word          d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  // physical memory side
  output logic              pmem_read,
  output logic              pmem_write,
  output lc3b_word          pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  // performance counters
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  // current FSM state, for debug visibility
  output arb_state_t        dbg_state
);

  arb_state_t        state;
  lc3b_grant         last_grant;
  lc3b_word          lat_address;
  logic [LINE_W-1:0] lat_wdata;

  logic ireq;
  logic dreq;
  logic grant_d;
  logic grant_i;
  logic conflict_inc;
  logic d_grant_inc;

  assign ireq = i_read;
  assign dreq = d_read | d_write;

  // D wins when it is alone, or on a conflict when I was granted last.
  assign grant_d = (state == IDLE) && dreq && (!ireq || (last_grant == GRANT_I));
  assign grant_i = (state == IDLE) && ireq && !grant_d;

  assign conflict_inc = (state == IDLE) && ireq && dreq;
  assign d_grant_inc  = grant_d;

  // Arbitration FSM, grant latching and registered memory command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_I;
      lat_address <= '0;
      lat_wdata   <= '0;
      pmem_read   <= 1'b0;
      pmem_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= SERVE_D;
            last_grant  <= GRANT_D;
            lat_address <= d_address;
            lat_wdata   <= d_wdata;
            // A simultaneous read and write is treated as a writeback.
            pmem_write  <= d_write;
            pmem_read   <= !d_write;
          end else if (grant_i) begin
            state       <= SERVE_I;
            last_grant  <= GRANT_I;
            lat_address <= i_address;
            lat_wdata   <= '0;
            pmem_write  <= 1'b0;
            pmem_read   <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Memory address and data come only from the grant-time latches.
  assign pmem_address = lat_address;
  assign pmem_wdata   = lat_wdata;

  // Route the completion only to the cache being served; a pmem_resp seen in
  // IDLE or DONE goes nowhere.
  assign i_resp  = (state == SERVE_I) && pmem_resp;
  assign d_resp  = (state == SERVE_D) && pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  assign dbg_state = state;

  // Cycles in IDLE where both caches were asking at once.
  sat_counter #(.W(CNT_W)) u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (conflict_inc),
    .count (conflict_cnt)
  );

  // Number of grants given to the D-cache.
  sat_counter #(.W(CNT_W)) u_d_grant_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (d_grant_inc),
    .count (d_grant_cnt)
  );

endmodule
